// File: rtl/mpc_decode_stage.sv
// Elastic instruction decode stage: combinational field/format/immediate decode feeding
// an output register backed by one skid register, with flush and async active-low reset.
module mpc_decode_stage #(
  parameter int INSTR_WIDTH  = 32,
  parameter int OP_WIDTH     = 6,
  parameter int REG_WIDTH    = 5,
  parameter int FU_WIDTH     = 6,
  parameter int IMM_WIDTH    = 16,
  parameter int TARGET_WIDTH = 26,
  parameter int DATA_WIDTH   = 32,
  parameter int PC_WIDTH     = 32
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    iValid,
  output logic                    oReady,
  input  logic [INSTR_WIDTH-1:0]  iInstr,
  input  logic [PC_WIDTH-1:0]     iPC,
  input  logic                    iFlush,
  output logic                    oValid,
  input  logic                    iReady,
  output logic [OP_WIDTH-1:0]     oOperation,
  output logic [FU_WIDTH-1:0]     oFunctor,
  output logic [2:0]              oFormat,
  output logic [REG_WIDTH-1:0]    oRs,
  output logic [REG_WIDTH-1:0]    oRt,
  output logic [REG_WIDTH-1:0]    oRd,
  output logic [REG_WIDTH-1:0]    oShamt,
  output logic [DATA_WIDTH-1:0]   oImmExt,
  output logic [PC_WIDTH-1:0]     oTargetAddr,
  output logic                    oSFP,
  output logic                    oDFP,
  output logic [PC_WIDTH-1:0]     oPC,
  output logic [1:0]              dbg_state
);

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b10;

  localparam int RS_LSB = INSTR_WIDTH - OP_WIDTH - REG_WIDTH;
  localparam int RT_LSB = RS_LSB - REG_WIDTH;
  localparam int RD_LSB = RT_LSB - REG_WIDTH;
  localparam int SH_LSB = RD_LSB - REG_WIDTH;

  localparam logic [OP_WIDTH-1:0]  OP_RTYPE = OP_WIDTH'('h00);
  localparam logic [OP_WIDTH-1:0]  OP_J     = OP_WIDTH'('h02);
  localparam logic [OP_WIDTH-1:0]  OP_JAL   = OP_WIDTH'('h03);
  localparam logic [OP_WIDTH-1:0]  OP_ANDI  = OP_WIDTH'('h0C);
  localparam logic [OP_WIDTH-1:0]  OP_ORI   = OP_WIDTH'('h0D);
  localparam logic [OP_WIDTH-1:0]  OP_XORI  = OP_WIDTH'('h0E);
  localparam logic [OP_WIDTH-1:0]  OP_LUI   = OP_WIDTH'('h0F);
  localparam logic [OP_WIDTH-1:0]  OP_COP1  = OP_WIDTH'('h11);
  localparam logic [REG_WIDTH-1:0] FMT_S    = REG_WIDTH'('h10);
  localparam logic [REG_WIDTH-1:0] FMT_D    = REG_WIDTH'('h11);

  // Bits of PC+4 replaced by {target, 2'b00}; all ones when the target fills the PC.
  localparam logic [PC_WIDTH-1:0] LOW_MASK =
    (PC_WIDTH'(1) << (TARGET_WIDTH + 2)) - PC_WIDTH'(1);

  typedef struct packed {
    logic [OP_WIDTH-1:0]   op;
    logic [FU_WIDTH-1:0]   fu;
    logic [2:0]            fmt;
    logic [REG_WIDTH-1:0]  rs;
    logic [REG_WIDTH-1:0]  rt;
    logic [REG_WIDTH-1:0]  rd;
    logic [REG_WIDTH-1:0]  shamt;
    logic [DATA_WIDTH-1:0] imm_ext;
    logic [PC_WIDTH-1:0]   target;
    logic                  sfp;
    logic                  dfp;
    logic [PC_WIDTH-1:0]   pc;
  } dec_t;

  logic [IMM_WIDTH-1:0]    imm_field;
  logic [TARGET_WIDTH-1:0] target_field;
  logic [PC_WIDTH-1:0]     pc_plus4;
  dec_t                    dec;

  assign imm_field    = iInstr[IMM_WIDTH-1:0];
  assign target_field = iInstr[TARGET_WIDTH-1:0];
  assign pc_plus4     = iPC + PC_WIDTH'(4);

  always_comb begin
    dec       = '0;
    dec.op    = iInstr[INSTR_WIDTH-1 -: OP_WIDTH];
    dec.rs    = iInstr[RS_LSB +: REG_WIDTH];
    dec.rt    = iInstr[RT_LSB +: REG_WIDTH];
    dec.rd    = iInstr[RD_LSB +: REG_WIDTH];
    dec.shamt = iInstr[SH_LSB +: REG_WIDTH];
    dec.fu    = iInstr[FU_WIDTH-1:0];
    if (dec.op == OP_RTYPE)                    dec.fmt = 3'b001;
    else if (dec.op == OP_J || dec.op == OP_JAL) dec.fmt = 3'b100;
    else                                       dec.fmt = 3'b010;
    dec.sfp = (dec.op == OP_COP1) && (dec.rs == FMT_S);
    dec.dfp = (dec.op == OP_COP1) && (dec.rs == FMT_D);
    // Logical immediates zero-extend, LUI shifts to the top, everything else sign-extends.
    if (dec.op == OP_ANDI || dec.op == OP_ORI || dec.op == OP_XORI)
      dec.imm_ext = DATA_WIDTH'(imm_field);
    else if (dec.op == OP_LUI)
      dec.imm_ext = DATA_WIDTH'(imm_field) << (DATA_WIDTH - IMM_WIDTH);
    else
      dec.imm_ext = DATA_WIDTH'($signed(imm_field));
    dec.target = (pc_plus4 & ~LOW_MASK) | (PC_WIDTH'(target_field) << 2);
    dec.pc     = iPC;
  end

  // Handshake: a beat moves on a side only when its valid and ready are both high in the
  // same cycle; a producer holding valid keeps its data stable until that happens.
  logic [1:0] state_q, state_d;
  dec_t       out_q, out_d;
  dec_t       skid_q, skid_d;
  logic       in_xfer;
  logic       out_xfer;

  assign oValid   = (state_q != ST_EMPTY);
  assign oReady   = resetn & (state_q != ST_FULL);
  assign in_xfer  = iValid & oReady;
  assign out_xfer = oValid & iReady;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          out_d   = dec;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          out_d = dec;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end else if (in_xfer) begin
          skid_d  = dec;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (out_xfer) begin
          out_d   = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (iFlush) state_d = ST_EMPTY;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  assign oOperation  = out_q.op;
  assign oFunctor    = out_q.fu;
  assign oFormat     = out_q.fmt;
  assign oRs         = out_q.rs;
  assign oRt         = out_q.rt;
  assign oRd         = out_q.rd;
  assign oShamt      = out_q.shamt;
  assign oImmExt     = out_q.imm_ext;
  assign oTargetAddr = out_q.target;
  assign oSFP        = out_q.sfp;
  assign oDFP        = out_q.dfp;
  assign oPC         = out_q.pc;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mpc_decode_stage.sv
// Directed bench for mpc_decode_stage: decode fields, immediates, jump/FP classes,
// backpressure ordering through the skid register, flush and asynchronous reset.
module tb_mpc_decode_stage;

  logic        clk;
  logic        resetn;
  logic        iValid;
  logic        oReady;
  logic [31:0] iInstr;
  logic [31:0] iPC;
  logic        iFlush;
  logic        oValid;
  logic        iReady;
  logic [5:0]  oOperation;
  logic [5:0]  oFunctor;
  logic [2:0]  oFormat;
  logic [4:0]  oRs;
  logic [4:0]  oRt;
  logic [4:0]  oRd;
  logic [4:0]  oShamt;
  logic [31:0] oImmExt;
  logic [31:0] oTargetAddr;
  logic        oSFP;
  logic        oDFP;
  logic [31:0] oPC;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fails  = 0;

  localparam logic [1:0] S_EMPTY = 2'b00;
  localparam logic [1:0] S_ONE   = 2'b01;
  localparam logic [1:0] S_FULL  = 2'b10;

  mpc_decode_stage dut (
    .clk(clk), .resetn(resetn),
    .iValid(iValid), .oReady(oReady), .iInstr(iInstr), .iPC(iPC), .iFlush(iFlush),
    .oValid(oValid), .iReady(iReady),
    .oOperation(oOperation), .oFunctor(oFunctor), .oFormat(oFormat),
    .oRs(oRs), .oRt(oRt), .oRd(oRd), .oShamt(oShamt),
    .oImmExt(oImmExt), .oTargetAddr(oTargetAddr),
    .oSFP(oSFP), .oDFP(oDFP), .oPC(oPC), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver
  task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
    iValid = 1'b1;
    iInstr = instr;
    iPC    = pc;
  endtask

  initial begin
    resetn = 1'b0;
    iValid = 1'b0;
    iInstr = '0;
    iPC    = '0;
    iFlush = 1'b0;
    iReady = 1'b0;
    #12;
    check("rst_ovalid", oValid, 0);
    check("rst_oready", oReady, 0);
    check("rst_oper", oOperation, 0);
    check("rst_imm", oImmExt, 0);
    check("rst_pc", oPC, 0);
    check("rst_state", dbg_state, S_EMPTY);
    #6 resetn = 1'b1;
    #1;
    check("post_rst_oready", oReady, 1);
    check("post_rst_ovalid", oValid, 0);

    // R-type add $3,$1,$2
    iReady = 1'b1;
    offer(32'h0022_1820, 32'h0040_0000);
    tick();
    iValid = 1'b0;
    check("add_valid", oValid, 1);
    check("add_fmt", oFormat, 3'b001);
    check("add_rs", oRs, 1);
    check("add_rt", oRt, 2);
    check("add_rd", oRd, 3);
    check("add_shamt", oShamt, 0);
    check("add_fu", oFunctor, 6'h20);
    check("add_pc", oPC, 32'h0040_0000);

    // immediate extension, back-to-back
    offer(32'h2001_FFFF, 32'h0040_0004);
    tick();
    check("addi_imm", oImmExt, 32'hFFFF_FFFF);
    check("addi_fmt", oFormat, 3'b010);
    offer(32'h3401_FFFF, 32'h0040_0008);
    tick();
    check("ori_imm", oImmExt, 32'h0000_FFFF);
    check("ori_fmt", oFormat, 3'b010);
    offer(32'h3C01_1234, 32'h0040_000C);
    tick();
    check("lui_imm", oImmExt, 32'h1234_0000);
    check("lui_fmt", oFormat, 3'b010);
    check("lui_valid", oValid, 1);

    // jump and FP class
    offer(32'h0800_0010, 32'h4000_0000);
    tick();
    check("j_fmt", oFormat, 3'b100);
    check("j_target", oTargetAddr, 32'h4000_0040);
    offer(32'h4600_0000, 32'h4000_0004);
    tick();
    check("sfp_s", oSFP, 1);
    check("sfp_d", oDFP, 0);
    check("sfp_op", oOperation, 6'h11);
    offer(32'h4620_0000, 32'h4000_0008);
    tick();
    check("dfp_s", oSFP, 0);
    check("dfp_d", oDFP, 1);
    iValid = 1'b0;
    tick();
    check("drain_valid", oValid, 0);
    check("drain_state", dbg_state, S_EMPTY);

    // backpressure: A held, B in skid, C stalled
    iReady = 1'b0;
    offer(32'h0022_1820, 32'h0000_0100);
    tick();
    check("bp_a_state", dbg_state, S_ONE);
    check("bp_a_ready", oReady, 1);
    offer(32'h2001_FFFF, 32'h0000_0104);
    tick();
    check("bp_full_state", dbg_state, S_FULL);
    check("bp_full_ready", oReady, 0);
    offer(32'h3C01_1234, 32'h0000_0108);
    tick();
    check("bp_hold_pc", oPC, 32'h0000_0100);
    check("bp_hold_op", oOperation, 6'h00);
    check("bp_hold_ready", oReady, 0);
    iReady = 1'b1;
    tick();
    check("bp_b_valid", oValid, 1);
    check("bp_b_pc", oPC, 32'h0000_0104);
    check("bp_b_imm", oImmExt, 32'hFFFF_FFFF);
    check("bp_b_ready", oReady, 1);
    tick();
    iValid = 1'b0;
    check("bp_c_valid", oValid, 1);
    check("bp_c_pc", oPC, 32'h0000_0108);
    check("bp_c_imm", oImmExt, 32'h1234_0000);
    tick();
    check("bp_end_valid", oValid, 0);

    // flush while FULL with a new instruction offered
    iReady = 1'b0;
    offer(32'h0022_1820, 32'h0000_0200);
    tick();
    offer(32'h2001_FFFF, 32'h0000_0204);
    tick();
    check("fl_pre_state", dbg_state, S_FULL);
    iFlush = 1'b1;
    offer(32'h3401_FFFF, 32'h0000_0208);
    tick();
    iFlush = 1'b0;
    iValid = 1'b0;
    check("fl_valid", oValid, 0);
    check("fl_ready", oReady, 1);
    check("fl_state", dbg_state, S_EMPTY);
    iReady = 1'b1;
    tick();
    check("fl_stay_empty", oValid, 0);
    offer(32'h0800_0010, 32'h0000_020C);
    tick();
    iValid = 1'b0;
    check("fl_next_valid", oValid, 1);
    check("fl_next_pc", oPC, 32'h0000_020C);
    check("fl_next_fmt", oFormat, 3'b100);
    tick();
    check("fl_next_once", oValid, 0);

    // asynchronous reset in the middle of a stalled stream
    iReady = 1'b0;
    offer(32'h4600_0000, 32'h0000_0300);
    tick();
    offer(32'h4620_0000, 32'h0000_0304);
    tick();
    iValid = 1'b0;
    check("ar_pre_state", dbg_state, S_FULL);
    #2 resetn = 1'b0;
    #1;
    check("ar_valid", oValid, 0);
    check("ar_ready", oReady, 0);
    check("ar_pc", oPC, 0);
    check("ar_sfp", oSFP, 0);
    check("ar_fmt", oFormat, 0);
    check("ar_target", oTargetAddr, 0);
    #3 resetn = 1'b1;
    #1;
    check("ar_rel_ready", oReady, 1);
    iReady = 1'b1;
    offer(32'h3401_FFFF, 32'h0000_0400);
    tick();
    iValid = 1'b0;
    check("ar_first_valid", oValid, 1);
    check("ar_first_imm", oImmExt, 32'h0000_FFFF);
    check("ar_first_pc", oPC, 32'h0000_0400);
    check("ar_first_rt", oRt, 1);
    tick();
    check("ar_first_once", oValid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mpc_decode_stage.md
Name: mpc_decode_stage

Overview:
Parametrised, elastic successor of the instruction decode unit. It sits between the fetch stage and register-read/issue, and decodes one instruction per cycle into fields, format class and FP class.
- Immediate is sign- or zero-extended to DATA_WIDTH.
- Jump target is formed from the PC.
- A valid/ready handshake with a 2-entry skid buffer gives full throughput under backpressure.
- A pipeline flush is supported.

Parameters:
INSTR_WIDTH, 32, instruction width
OP_WIDTH, 6, opcode field width (top bits)
REG_WIDTH, 5, register specifier width
FU_WIDTH, 6, function field width (bottom bits)
IMM_WIDTH, 16, immediate field width
TARGET_WIDTH, 26, jump target field width
DATA_WIDTH, 32, extended immediate width (must be >= IMM_WIDTH)
PC_WIDTH, 32, PC width (must be >= TARGET_WIDTH+2)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
iValid  in  1  fetch offers instruction
oReady  out  1  stage can accept
iInstr  in  INSTR_WIDTH  instruction
iPC  in  PC_WIDTH  instruction address
iFlush  in  1  discard all held/incoming instructions
oValid  out  1  decoded instruction valid
iReady  in  1  downstream accepts
oOperation  out  OP_WIDTH  opcode
oFunctor  out  FU_WIDTH  function field
oFormat  out  3  one-hot {J,I,R}
oRs/oRt/oRd  out  REG_WIDTH each  register fields
oShamt  out  REG_WIDTH  shift amount field (bits directly below rd)
oImmExt  out  DATA_WIDTH  extended immediate
oTargetAddr  out  PC_WIDTH  jump target address
oSFP  out  1  single-precision FP instruction
oDFP  out  1  double-precision FP instruction
oPC  out  PC_WIDTH  PC of decoded instruction

Behaviour:
- Clock and reset: single clock domain (clk). resetn is asynchronous and active-low; all state clears immediately when it is asserted.
- Reset values: all outputs 0. oReady is 1 once resetn deasserts.
- Field extraction: opcode = top OP_WIDTH bits; rs, rt, rd, shamt follow contiguously downward; funct = low FU_WIDTH bits.
- Format decode: R if opcode=0x00; J if opcode=0x02 or 0x03; otherwise I. Exactly one oFormat bit is set when oValid=1.
- FP decode:
  - oSFP = (opcode=0x11) and (rs=0x10).
  - oDFP = (opcode=0x11) and (rs=0x11).
- Immediate extension:
  - opcodes 0x0C/0x0D/0x0E: zero-extended.
  - opcode 0x0F (LUI): imm placed in the top IMM_WIDTH bits, low bits 0.
  - all other opcodes: sign-extended.
- Jump target: oTargetAddr = {upper PC_WIDTH-TARGET_WIDTH-2 bits of (iPC+4), target field, 2'b00}. Computed for every instruction regardless of format.
- Latency: decode is combinational into the output register, so results appear 1 cycle after the accepting edge.
- Handshake:
  - Input transfer occurs when iValid & oReady.
  - Output transfer occurs when oValid & iReady.
  - Output holds stable while oValid & ~iReady.
- Buffer states:
  - EMPTY: oValid=0, oReady=1.
  - ONE: output register full; oReady=1.
  - FULL: output register and skid register both full; oReady=0.
- Transitions:
  - EMPTY -> ONE on input transfer.
  - ONE -> ONE on simultaneous input and output transfer.
  - ONE -> EMPTY on output transfer only.
  - ONE -> FULL on input transfer with output stalled; the decoded data goes into the skid register.
  - FULL -> ONE on output transfer; the skid register moves to the output register.
- oReady timing: oReady is registered and equals ~skid_full, so it never depends combinationally on iReady.
- Ordering: instructions leave in acceptance order; none is dropped or duplicated.
- Flush:
  - iFlush clears both valids at the next edge, regardless of the iValid/iReady state that cycle.
  - An instruction offered in the flush cycle is discarded.
  - The state after a flush is EMPTY.
- Reset mid-operation: all held instructions are lost; outputs return to 0 asynchronously.

Test Plan:
- Accept 0x00221820 (add $3,$1,$2) at PC 0x00400000, iReady=1 -> next cycle oValid=1, oFormat=001, oRs=1, oRt=2, oRd=3, oFunctor=0x20, oPC=0x00400000.
- Send 0x2001FFFF, then 0x3401FFFF, then 0x3C011234 -> oImmExt = 0xFFFFFFFF, 0x0000FFFF, 0x12340000; oFormat=010 for each.
- Send 0x08000010 at PC 0x40000000 -> oFormat=100, oTargetAddr=0x40000040. Then send 0x46000000 -> oSFP=1, oDFP=0. Then send 0x46200000 -> oSFP=0, oDFP=1.
- Backpressure: hold iReady=0, stream 3 instructions A, B, C with iValid=1 -> A held on output, B in skid, oReady=0, C stalled. Raise iReady -> A, B, C delivered in order with no gaps or duplicates.
- Assert iFlush while in FULL with iValid=1 -> next cycle oValid=0, oReady=1. The flushed instruction and the incoming instruction never appear on the output.
- Assert resetn=0 mid-stream -> all outputs 0 immediately. After release, the first accepted instruction decodes correctly.
